line_window_gen: RTL and testbench

LINE_WINDOW_GEN -- requirements
Module: line_window_gen

---
 rtl/img_proc_pkg.sv | 22 ++
 rtl/line_buf.sv | 33 +++
 rtl/line_window_gen.sv | 125 ++++++++++++
 tb/tb_line_window_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/img_proc_pkg.sv
// -----------------------------------------------------------------------------
// img_proc_pkg
// Shared definitions for the image-processing line-window blocks.
//   state_t        : window generator control state (IDLE / FILL / RUN)
//   KSZ_SMALL/LARGE: the only window heights the generator supports
// -----------------------------------------------------------------------------
package img_proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int KSZ_SMALL = 3;
  localparam int KSZ_LARGE = 5;

  function automatic bit ksz_legal(input int ksz);
    return (ksz == KSZ_SMALL) || (ksz == KSZ_LARGE);
  endfunction

endpackage

// File: rtl/line_buf.sv
// -----------------------------------------------------------------------------
// line_buf
// Simple dual-port line memory, one write port and one synchronous read port
// with a single cycle of read latency. A read and write to the same address in
// the same cycle returns the old contents. Contents are never reset.
//   clk     : clock, rising edge
//   i_we    : write enable
//   i_waddr : write column
//   i_wdata : write data
//   i_raddr : read column (presented one cycle before the data is needed)
//   o_rdata : registered read data
// -----------------------------------------------------------------------------
module line_buf #(
  parameter int DW    = 14,
  parameter int DEPTH = 640,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/line_window_gen.sv
// -----------------------------------------------------------------------------
// line_window_gen
// Turns a raster pixel stream into KSZ-tall vertical columns: for every pixel
// accepted once KSZ-1 full lines of the current frame are buffered, dout holds
// that pixel plus the pixels in the same column on the KSZ-1 lines above it.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset (line memories not cleared)
//   frame_start : marks the first pixel of a frame (only with din_valid)
//   din         : raster pixel
//   din_valid   : din qualifier, one pixel per asserted cycle
//   dout        : taps, slice 0 = current line, slice k = k lines above
//   dout_valid  : dout qualifier, one cycle after the qualifying pixel
//   dout_sol    : dout belongs to column 0
//   dout_eol    : dout belongs to column IW-1
// -----------------------------------------------------------------------------
module line_window_gen
  import img_proc_pkg::*;
#(
  parameter int DW  = 14,
  parameter int KSZ = 3,
  parameter int IW  = 640,
  parameter int AW  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [DW-1:0]     din,
  input  logic              din_valid,
  output logic [KSZ*DW-1:0] dout,
  output logic              dout_valid,
  output logic              dout_sol,
  output logic              dout_eol
);

  if (!ksz_legal(KSZ)) begin : g_bad_ksz
    $error("line_window_gen: KSZ must be 3 or 5");
  end

  localparam int            NB        = KSZ - 1;
  localparam logic [AW-1:0] COL_LAST  = AW'(IW - 1);
  localparam logic [2:0]    LINE_SAT  = 3'(KSZ - 1);
  localparam logic [2:0]    LINE_LAST = 3'(KSZ - 2);

  state_t        r_state;
  logic [AW-1:0] r_col;
  logic [2:0]    r_line;

  logic          w_accept;
  logic [AW-1:0] w_pix_col;
  logic [2:0]    w_pix_line;
  logic          w_wrap;
  logic [AW-1:0] w_col_next;
  logic          w_out_en;
  logic [DW-1:0] w_rd [NB];
  logic [DW-1:0] w_wr [NB];
  logic [KSZ*DW-1:0] w_taps;

  // A frame_start pixel is column 0 / line 0 regardless of the counters.
  assign w_accept   = din_valid & (frame_start | (r_state != ST_IDLE));
  assign w_pix_col  = frame_start ? '0 : r_col;
  assign w_pix_line = frame_start ? '0 : r_line;
  assign w_wrap     = (w_pix_col == COL_LAST);
  assign w_col_next = !w_accept ? r_col : (w_wrap ? '0 : w_pix_col + AW'(1));
  assign w_out_en   = w_accept & ~frame_start & (r_state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_line  <= '0;
    end else if (w_accept) begin
      r_col <= w_col_next;
      if (w_wrap) r_line <= (w_pix_line == LINE_SAT) ? w_pix_line : w_pix_line + 3'd1;
      else        r_line <= w_pix_line;
      if (frame_start)
        r_state <= ST_FILL;
      else if ((r_state == ST_FILL) && w_wrap && (w_pix_line == LINE_LAST))
        r_state <= ST_RUN;
    end
  end

  // The read port is driven with the column the next accepted pixel will
  // occupy, so the buffered column is already on w_rd when that pixel
  // arrives. A frame_start pixel breaks this look-ahead, but only the writes
  // into buffer 0 matter on line 0 and those take din directly.
  for (genvar k = 0; k < NB; k++) begin : g_buf
    if (k == 0) begin : g_first
      assign w_wr[k] = din;
    end else begin : g_chain
      assign w_wr[k] = w_rd[k-1];
    end
    line_buf #(.DW(DW), .DEPTH(IW), .AW(AW)) u_line_buf (
      .clk     (clk),
      .i_we    (w_accept),
      .i_waddr (w_pix_col),
      .i_wdata (w_wr[k]),
      .i_raddr (w_col_next),
      .o_rdata (w_rd[k])
    );
  end

  always_comb begin
    w_taps = '0;
    w_taps[DW-1:0] = din;
    for (int k = 0; k < NB; k++) w_taps[(k+1)*DW +: DW] = w_rd[k];
  end

  // Output stage: data and flags only move on a valid RUN pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sol   <= 1'b0;
      dout_eol   <= 1'b0;
    end else begin
      dout_valid <= w_out_en;
      if (w_out_en) begin
        dout     <= w_taps;
        dout_sol <= (w_pix_col == '0);
        dout_eol <= w_wrap;
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// -----------------------------------------------------------------------------
// tb_line_window_gen
// Drives a 3-tall and a 5-tall window generator (DW=8, IW=4) from one shared
// pixel stream and compares both against a frame-history model: each accepted
// pixel is appended to the current frame, its tap k is the pixel k*IW earlier
// in that frame, and it is valid once it sits on line KSZ-1 or later.
// -----------------------------------------------------------------------------
module tb_line_window_gen;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic frame_start;
  logic [DW-1:0] din;
  logic din_valid;

  logic [3*DW-1:0] dout3;
  logic dout_valid3, dout_sol3, dout_eol3;
  logic [5*DW-1:0] dout5;
  logic dout_valid5, dout_sol5, dout_eol5;

  always #5 clk = ~clk;

  line_window_gen #(.DW(DW), .KSZ(3), .IW(IW), .AW(AW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .din(din),
    .din_valid(din_valid), .dout(dout3), .dout_valid(dout_valid3),
    .dout_sol(dout_sol3), .dout_eol(dout_eol3));

  line_window_gen #(.DW(DW), .KSZ(5), .IW(IW), .AW(AW)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .din(din),
    .din_valid(din_valid), .dout(dout5), .dout_valid(dout_valid5),
    .dout_sol(dout_sol5), .dout_eol(dout_eol5));

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit             active;
  logic [DW-1:0]  hist[$];
  logic [3*DW-1:0] e3_dout;
  logic            e3_v, e3_sol, e3_eol;
  logic [5*DW-1:0] e5_dout;
  logic            e5_v, e5_sol, e5_eol;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    active = 1'b0;
    hist.delete();
    e3_dout = '0; e3_v = 1'b0; e3_sol = 1'b0; e3_eol = 1'b0;
    e5_dout = '0; e5_v = 1'b0; e5_sol = 1'b0; e5_eol = 1'b0;
  endtask

  task automatic model_step(input logic fs, input logic v, input logic [DW-1:0] d);
    int n, line, col;
    e3_v = 1'b0;
    e5_v = 1'b0;
    if (v) begin
      if (fs) begin
        active = 1'b1;
        hist.delete();
      end
      if (active) begin
        hist.push_back(d);
        n    = hist.size() - 1;
        line = n / IW;
        col  = n % IW;
        if (line >= 2) begin
          e3_v = 1'b1;
          for (int k = 0; k < 3; k++) e3_dout[k*DW +: DW] = hist[n - k*IW];
          e3_sol = (col == 0);
          e3_eol = (col == IW - 1);
        end
        if (line >= 4) begin
          e5_v = 1'b1;
          for (int k = 0; k < 5; k++) e5_dout[k*DW +: DW] = hist[n - k*IW];
          e5_sol = (col == 0);
          e5_eol = (col == IW - 1);
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid3"}, 64'(dout_valid3), 64'(e3_v));
    check({tag, ".dout3"},  64'(dout3),       64'(e3_dout));
    check({tag, ".sol3"},   64'(dout_sol3),   64'(e3_sol));
    check({tag, ".eol3"},   64'(dout_eol3),   64'(e3_eol));
    check({tag, ".valid5"}, 64'(dout_valid5), 64'(e5_v));
    check({tag, ".dout5"},  64'(dout5),       64'(e5_dout));
    check({tag, ".sol5"},   64'(dout_sol5),   64'(e5_sol));
    check({tag, ".eol5"},   64'(dout_eol5),   64'(e5_eol));
  endtask

  // One clock: apply inputs, let the edge happen, check 1 ns later.
  task automatic step(input string tag, input logic fs, input logic v, input logic [DW-1:0] d);
    frame_start = fs;
    din_valid   = v;
    din         = d;
    @(posedge clk);
    #1;
    model_step(fs, v, d);
    compare_all(tag);
  endtask

  initial begin
    logic fs_r, v_r;
    rst_n = 1'b0;
    frame_start = 1'b0;
    din_valid = 1'b0;
    din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    #3 rst_n = 1'b1;

    // Pixels before any frame_start are ignored
    for (int i = 0; i < 5; i++) step("preframe", 1'b0, 1'b1, DW'($urandom));

    // Contiguous frame, pixels 1..20
    step("contig", 1'b1, 1'b1, 8'd1);
    for (int i = 2; i <= 20; i++) begin
      step("contig", 1'b0, 1'b1, DW'(i));
      if (i == 9) begin
        check("k3_px9_dout", 64'(dout3), 64'(24'h010509));
        check("k3_px9_sol",  64'(dout_sol3), 64'd1);
      end
      if (i == 12) begin
        check("k3_px12_dout", 64'(dout3), 64'(24'h04080c));
        check("k3_px12_eol",  64'(dout_eol3), 64'd1);
      end
      if (i == 17) begin
        check("k5_px17_dout", 64'(dout5), 64'(40'h0105090d11));
        check("k5_px17_sol",  64'(dout_sol5), 64'd1);
      end
    end

    // Same stream with din_valid low every other cycle
    step("gappy", 1'b1, 1'b1, 8'd1);
    for (int i = 2; i <= 12; i++) begin
      step("gappy_idle", 1'b0, 1'b0, DW'($urandom));
      step("gappy", 1'b0, 1'b1, DW'(i));
      if (i == 9) check("gappy_px9_dout", 64'(dout3), 64'(24'h010509));
    end

    // Restart on pixel 13: new frame values 101, 102, ...
    step("refr", 1'b1, 1'b1, 8'd1);
    for (int i = 2; i <= 12; i++) step("refr", 1'b0, 1'b1, DW'(i));
    step("refr_new", 1'b1, 1'b1, 8'd101);
    for (int j = 2; j <= 9; j++) step("refr_new", 1'b0, 1'b1, DW'(100 + j));
    check("refr_first_dout",  64'(dout3), 64'(24'h65696d));
    check("refr_first_valid", 64'(dout_valid3), 64'd1);

    // Asynchronous reset after pixel 6 of a frame
    step("rst_mid", 1'b1, 1'b1, 8'd1);
    for (int i = 2; i <= 6; i++) step("rst_mid", 1'b0, 1'b1, DW'(i));
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step("post_rst", 1'b0, 1'b1, DW'($urandom));

    // Randomised frames: gaps, stray frame_start, restarts mid-frame
    for (int f = 0; f < 8; f++) begin
      step("rand_fs", 1'b1, 1'b1, DW'($urandom));
      for (int i = 0; i < 60; i++) begin
        v_r  = ($urandom_range(0, 3) != 0);
        fs_r = ($urandom_range(0, 49) == 0);
        step("rand", fs_r, v_r, DW'($urandom));
      end
    end

    frame_start = 1'b0;
    din_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
